// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Contents: state_t (4-bit FSM state), opcode constants, ALU class,
// PC source and ALU operand-B select encodings, and a helper that flags
// the states which wait on the memory handshake.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12,
    TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // ALU decoder class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source: ALU result, registered ALU result (branch target), jump target
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU operand B: register, constant 4, sign-extended imm, shifted imm
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles spent in one memory
// state and flags when the tolerated budget is exhausted.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : owning FSM changes state this cycle
//   stall      : in a memory-wait state with mem_ready low
//   timeout    : stall seen with MAX_WAIT stalls already counted
module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic stall,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt never passes MAX_WAIT: reaching it with a stall forces a state
  // change, which clears the counter.
  assign timeout = stall && (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore-style sequencer for the multicycle MIPS
// datapath. One memory port and one ALU are shared across cycles; memory
// states wait on mem_ready with a bounded stall budget.
// Optional feature macro: MC_CTRL_BNE_EN (adds bne via BNEEX state).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   op_code             : IR[31:26], valid from DECODE onward
//   mem_ready           : memory completes current access this cycle
//   mem_req             : memory access in progress
//   mem_write, ir_write, pc_write, reg_write : write strobes
//   branch, branch_ne   : conditional PC-write qualifiers
//   i_or_d, alu_src_a, reg_dst, mem_to_reg   : datapath mux selects
//   alu_src_b, pc_src, alu_op                : 2-bit selects / ALU class
//   illegal_op, mem_timeout                  : sticky error flags
//   state               : current FSM state (debug)
//
// state   | meaning
// FETCH   | read instruction, PC+4; waits on mem_ready
// DECODE  | register read, branch target precompute
// MEMADR  | effective address for lw/sw
// MEMRD   | data read; waits on mem_ready
// MEMWB   | load result to register file
// MEMWR   | data write; waits on mem_ready
// RTYPEEX | R-type ALU operation
// ALUWB   | R-type result to rd
// BEQEX   | compare, branch if equal
// ADDIEX  | rs + imm
// ADDIWB  | addi result to rt
// JEX     | jump
// BNEEX   | compare, branch if not equal (optional)
// TRAP    | illegal opcode or memory timeout; left only by reset
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
  parameter int OP_W     = 6,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_code,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            ir_write,
  output logic            pc_write,
  output logic            reg_write,
  output logic            branch,
  output logic            branch_ne,
  output logic            i_or_d,
  output logic            alu_src_a,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic [1:0]      alu_op,
  output logic            illegal_op,
  output logic            mem_timeout,
  output logic [3:0]      state
);

  state_t state_q, state_d;
  logic   ready;
  logic   stall;
  logic   timeout;
  logic   set_illegal;
  logic   illegal_q;
  logic   timeout_q;

  // Masking ready with rst_n keeps ir_write/pc_write low while reset is
  // held, even though the state register already reads FETCH.
  assign ready = mem_ready & rst_n;
  assign stall = is_wait_state(state_q) & ~ready;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_d != state_q),
    .stall   (stall),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | timeout;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    i_or_d      = 1'b0;
    alu_src_a   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PC_ALU;
    alu_op      = ALU_ADD;

    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        if (op_code == OP_W'(OP_RTYPE)) begin
          state_d = RTYPEEX;
        end else if ((op_code == OP_W'(OP_LW)) || (op_code == OP_W'(OP_SW))) begin
          state_d = MEMADR;
        end else if (op_code == OP_W'(OP_BEQ)) begin
          state_d = BEQEX;
        end else if (op_code == OP_W'(OP_ADDI)) begin
          state_d = ADDIEX;
        end else if (op_code == OP_W'(OP_J)) begin
          state_d = JEX;
`ifdef MC_CTRL_BNE_EN
        end else if (op_code == OP_W'(OP_BNE)) begin
          state_d = BNEEX;
`endif
        end else begin
          set_illegal = 1'b1;
          state_d     = TRAP;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_code == OP_W'(OP_SW)) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (ready) begin
          state_d = MEMWB;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JEX: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      BNEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        branch_ne = 1'b1;
        state_d   = FETCH;
      end
`endif
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a per-cycle vector table for the
// zero-wait instruction flows, then hand sequences for stalls, timeout,
// illegal opcode, bne and reset during a memory read.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op_code = 6'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, ir_write, pc_write, reg_write;
  logic       branch, branch_ne, i_or_d, alu_src_a, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       illegal_op, mem_timeout;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OP_W(6), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .branch(branch),
    .branch_ne(branch_ne), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  // {mem_req, mem_write, ir_write, pc_write, reg_write, branch, branch_ne,
  //  i_or_d, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op}
  logic [16:0] outv;
  assign outv = {mem_req, mem_write, ir_write, pc_write, reg_write, branch,
                 branch_ne, i_or_d, alu_src_a, reg_dst, mem_to_reg,
                 alu_src_b, pc_src, alu_op};

  localparam logic [16:0] E_FETCH_R = 17'b1_0_1_1_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] E_FETCH_W = 17'b1_0_0_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] E_ADR     = 17'b0_0_0_0_0_0_0_0_1_0_0_10_00_00;
  localparam logic [16:0] E_MEMRD   = 17'b1_0_0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [16:0] E_MEMWB   = 17'b0_0_0_0_1_0_0_0_0_0_1_00_00_00;
  localparam logic [16:0] E_MEMWR   = 17'b1_1_0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [16:0] E_RTYPE   = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_10;
  localparam logic [16:0] E_ALUWB   = 17'b0_0_0_0_1_0_0_0_0_1_0_00_00_00;
  localparam logic [16:0] E_BEQ     = 17'b0_0_0_0_0_1_0_0_1_0_0_00_01_01;
  localparam logic [16:0] E_ADDIWB  = 17'b0_0_0_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_JEX     = 17'b0_0_0_1_0_0_0_0_0_0_0_00_10_00;
  localparam logic [16:0] E_BNE     = 17'b0_0_0_0_0_0_1_0_1_0_0_00_01_01;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [5:0] op, input logic rdy, input state_t st,
                     input logic [16:0] out);
    vec_t v;
    v.op  = op;
    v.rdy = rdy;
    v.st  = st;
    v.out = out;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change at the falling edge, outputs sampled 1ns later.
  task automatic drive(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    op_code   = op;
    mem_ready = rdy;
    #1;
  endtask

  // Assert reset between edges, check the async effect and the masked
  // FETCH outputs, release on a falling edge with mem_ready low.
  task automatic do_reset();
    @(posedge clk);
    #3;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(FETCH));
    chk("rst_outputs", 32'(outv), 32'(E_FETCH_W));
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;

    op_code   = OP_LW;
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("init_rst_state", 32'(state), 32'(FETCH));
    chk("init_rst_outputs", 32'(outv), 32'(E_FETCH_W));
    chk("init_rst_flags", 32'({illegal_op, mem_timeout}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    // lw (one fetch stall first), sw, R-type, addi, beq, j, lw with read stall
    add(OP_LW, 1'b0, FETCH, E_FETCH_W);
    add(OP_LW, 1'b1, FETCH, E_FETCH_R);
    add(OP_LW, 1'b1, DECODE, E_DECODE);
    add(OP_LW, 1'b1, MEMADR, E_ADR);
    add(OP_LW, 1'b1, MEMRD, E_MEMRD);
    add(OP_LW, 1'b1, MEMWB, E_MEMWB);
    add(OP_SW, 1'b1, FETCH, E_FETCH_R);
    add(OP_SW, 1'b1, DECODE, E_DECODE);
    add(OP_SW, 1'b1, MEMADR, E_ADR);
    add(OP_SW, 1'b1, MEMWR, E_MEMWR);
    add(OP_RTYPE, 1'b1, FETCH, E_FETCH_R);
    add(OP_RTYPE, 1'b1, DECODE, E_DECODE);
    add(OP_RTYPE, 1'b1, RTYPEEX, E_RTYPE);
    add(OP_RTYPE, 1'b1, ALUWB, E_ALUWB);
    add(OP_ADDI, 1'b1, FETCH, E_FETCH_R);
    add(OP_ADDI, 1'b1, DECODE, E_DECODE);
    add(OP_ADDI, 1'b1, ADDIEX, E_ADR);
    add(OP_ADDI, 1'b1, ADDIWB, E_ADDIWB);
    add(OP_BEQ, 1'b1, FETCH, E_FETCH_R);
    add(OP_BEQ, 1'b1, DECODE, E_DECODE);
    add(OP_BEQ, 1'b1, BEQEX, E_BEQ);
    add(OP_J, 1'b1, FETCH, E_FETCH_R);
    add(OP_J, 1'b1, DECODE, E_DECODE);
    add(OP_J, 1'b1, JEX, E_JEX);
    add(OP_LW, 1'b1, FETCH, E_FETCH_R);
    add(OP_LW, 1'b1, DECODE, E_DECODE);
    add(OP_LW, 1'b1, MEMADR, E_ADR);
    add(OP_LW, 1'b0, MEMRD, E_MEMRD);
    add(OP_LW, 1'b1, MEMRD, E_MEMRD);
    add(OP_LW, 1'b1, MEMWB, E_MEMWB);

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_outputs", i), 32'(outv), 32'(tbl[i].out));
    end

    // sw with three not-ready cycles in MEMWR
    cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      drive(OP_SW, (k >= 4 && k <= 6) ? 1'b0 : 1'b1);
      if (mem_write) cnt++;
    end
    chk("sw_stall_cycle7_state", 32'(state), 32'(MEMWR));
    chk("sw_stall_mem_write_cycles", 32'(cnt), 32'd4);

    // Fetch stalls exactly MAX_WAIT cycles (first one is sw cycle 8)
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      drive(OP_J, 1'b0);
      if (k == 1) chk("sw_cycle8_state", 32'(state), 32'(FETCH));
      if (ir_write) cnt++;
    end
    chk("fetch_stall15_state", 32'(state), 32'(FETCH));
    drive(OP_J, 1'b1);
    chk("fetch_ready16_ir_write", 32'(ir_write), 32'd1);
    if (ir_write) cnt++;
    drive(OP_J, 1'b1);
    chk("fetch_ready16_next_state", 32'(state), 32'(DECODE));
    chk("fetch_ready16_no_timeout", 32'(mem_timeout), 32'd0);
    if (ir_write) cnt++;
    chk("fetch_ready16_ir_write_count", 32'(cnt), 32'd1);
    drive(OP_J, 1'b1);
    chk("j_after_stall_state", 32'(state), 32'(JEX));

    // Ready never arrives: 16 not-ready FETCH cycles, then TRAP
    for (int k = 1; k <= 16; k++) begin
      drive(OP_J, 1'b0);
      chk($sformatf("timeout_wait%0d_state", k), 32'(state), 32'(FETCH));
    end
    chk("timeout_flag_before_trap", 32'(mem_timeout), 32'd0);
    drive(OP_J, 1'b0);
    chk("timeout_trap_state", 32'(state), 32'(TRAP));
    chk("timeout_flag", 32'(mem_timeout), 32'd1);
    chk("timeout_no_illegal", 32'(illegal_op), 32'd0);
    do_reset();

    // Illegal opcode 111111
    drive(6'b111111, 1'b1);
    chk("illegal_fetch_state", 32'(state), 32'(FETCH));
    drive(6'b111111, 1'b1);
    chk("illegal_decode_state", 32'(state), 32'(DECODE));
    drive(6'b111111, 1'b1);
    chk("illegal_trap_state", 32'(state), 32'(TRAP));
    chk("illegal_flag", 32'(illegal_op), 32'd1);
    for (int k = 0; k < 20; k++) begin
      drive(6'b111111, k[0]);
      chk($sformatf("trap%0d_state", k), 32'(state), 32'(TRAP));
      chk($sformatf("trap%0d_outputs", k), 32'(outv), 32'd0);
    end
    do_reset();

    // Opcode 000101
    drive(OP_BNE, 1'b1);
    drive(OP_BNE, 1'b1);
    chk("bne_decode_state", 32'(state), 32'(DECODE));
    drive(OP_BNE, 1'b1);
`ifdef MC_CTRL_BNE_EN
    chk("bne_ex_state", 32'(state), 32'(BNEEX));
    chk("bne_ex_outputs", 32'(outv), 32'(E_BNE));
    drive(OP_BNE, 1'b0);
    chk("bne_return_state", 32'(state), 32'(FETCH));
`else
    chk("bne_off_trap_state", 32'(state), 32'(TRAP));
    chk("bne_off_illegal", 32'(illegal_op), 32'd1);
    chk("bne_off_branch_ne", 32'(branch_ne), 32'd0);
`endif
    do_reset();

    // Reset asserted while stalled in MEMRD
    drive(OP_LW, 1'b1);
    drive(OP_LW, 1'b1);
    drive(OP_LW, 1'b1);
    drive(OP_LW, 1'b0);
    chk("rst_memrd_pre_state", 32'(state), 32'(MEMRD));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_memrd_async_state", 32'(state), 32'(FETCH));
    cnt = 0;
    if (reg_write) cnt++;
    for (int k = 0; k < 3; k++) begin
      drive(OP_LW, 1'b1);
      if (reg_write) cnt++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(OP_LW, 1'b0);
      if (reg_write) cnt++;
    end
    chk("rst_memrd_after_state", 32'(state), 32'(FETCH));
    chk("rst_memrd_reg_write_pulses", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
